// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN skips leading-zero iterations of the dividend.
module div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam logic [1:0] S_FREE    = 2'd0;
  localparam logic [1:0] S_BY_ZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  logic [1:0]          r_state,  w_state_nxt;
  logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
  logic [DATA_W-1:0]   r_dvd,    w_dvd_nxt;
  logic [DATA_W-1:0]   r_dvs,    w_dvs_nxt;
  logic [DATA_W-1:0]   r_rem,    w_rem_nxt;
  logic                r_q_neg,  w_q_neg_nxt;
  logic                r_r_neg,  w_r_neg_nxt;
  logic                r_signed, w_signed_nxt;
  logic [2*DATA_W-1:0] r_result, w_result_nxt;
  logic                r_ready,  w_ready_nxt;

  logic [DATA_W-1:0]   w_abs1, w_abs2;
  logic [DATA_W:0]     w_rem_sh, w_diff;
  logic [DATA_W-1:0]   w_q_fix, w_r_fix;
  logic [DATA_W-1:0]   w_dvd_init;
  logic [CNT_W-1:0]    w_cnt_init;

  assign w_abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // One restoring step: bit DATA_W of the difference is its sign.
  assign w_rem_sh = {r_rem, r_dvd[DATA_W-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};

  assign w_q_fix = (r_signed && r_q_neg) ? -r_dvd : r_dvd;
  assign w_r_fix = (r_signed && r_r_neg) ? -r_rem : r_rem;

`ifdef DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] w_lz;

  always_comb begin
    w_lz = CNT_W'(DATA_W);
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (w_abs1[i]) w_lz = CNT_W'(int'(DATA_W) - 1 - i);
    end
  end

  // Leading zeros would only shift zeros through an empty remainder.
  assign w_dvd_init = w_abs1 << w_lz;
  assign w_cnt_init = w_lz;
`else
  assign w_dvd_init = w_abs1;
  assign w_cnt_init = '0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dvd_nxt    = r_dvd;
    w_dvs_nxt    = r_dvs;
    w_rem_nxt    = r_rem;
    w_q_neg_nxt  = r_q_neg;
    w_r_neg_nxt  = r_r_neg;
    w_signed_nxt = r_signed;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;

    case (r_state)
      S_FREE: begin
        w_result_nxt = '0;
        w_ready_nxt  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = S_BY_ZERO;
          end else begin
            w_state_nxt  = S_ON;
            w_dvd_nxt    = w_dvd_init;
            w_dvs_nxt    = w_abs2;
            w_rem_nxt    = '0;
            w_cnt_nxt    = w_cnt_init;
            w_q_neg_nxt  = opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1];
            w_r_neg_nxt  = opdata1_i[DATA_W-1];
            w_signed_nxt = signed_div_i;
          end
        end
      end
      S_BY_ZERO: begin
        w_state_nxt  = S_END;
        w_result_nxt = '0;
        w_ready_nxt  = 1'b1;
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nxt  = S_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end else if (r_cnt < CNT_W'(DATA_W)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_diff[DATA_W]) begin
            w_rem_nxt = DATA_W'(w_rem_sh);
            w_dvd_nxt = {r_dvd[DATA_W-2:0], 1'b0};
          end else begin
            w_rem_nxt = DATA_W'(w_diff);
            w_dvd_nxt = {r_dvd[DATA_W-2:0], 1'b1};
          end
        end else begin
          w_state_nxt  = S_END;
          w_result_nxt = {w_r_fix, w_q_fix};
          w_ready_nxt  = 1'b1;
        end
      end
      S_END: begin
        w_ready_nxt = 1'b1;
        if (!start_i) begin
          w_state_nxt  = S_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = S_FREE;
        w_result_nxt = '0;
        w_ready_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_signed <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
      r_rem    <= w_rem_nxt;
      r_q_neg  <= w_q_neg_nxt;
      r_r_neg  <= w_r_neg_nxt;
      r_signed <= w_signed_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor pops on ready_o rise.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_rdy = 1'b0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] m;
    int k;
`endif
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    m = (s && a[31]) ? -a : a;
    k = 32;
    for (int i = 0; i < 32; i++) if (m[i]) k = 31 - i;
    return 34 - k;
`else
    if (s && a[31]) return 34;
    return 34;
`endif
  endfunction

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ready_o === 1'b1 && prev_rdy !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got result %h with no pending request", result_o);
      end else begin
        e = sb.pop_front();
        check64({e.name, "_result"}, result_o, e.res);
        check64({e.name, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
      end
    end
    prev_rdy = ready_o;
  end

  task automatic wait_ready(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got ready_o=%b expected 1 within 60 cycles", nm, ready_o);
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string nm);
    exp_t e;
    @(negedge clk);
    e.res = exp; e.lat = lat_of(s, a, b); e.t0 = cyc; e.name = nm;
    sb.push_back(e);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(negedge clk);
    // Operands are scrambled after the start edge; only latched values may matter.
    signed_div_i = ~s; opdata1_i = $urandom; opdata2_i = $urandom;
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input string nm);
    bit ok;
    issue(s, a, b, exp, nm);
    wait_ready(nm, ok);
    if (ok) begin
      repeat (2) @(negedge clk);
      check64({nm, "_hold"}, {ready_o, result_o}, {1'b1, exp});
    end
    start_i = 1'b0;
    @(negedge clk);
    check64({nm, "_clear"}, {ready_o, result_o}, 65'd0);
  endtask

  initial begin
    bit ok;
    int mid;
    exp_t e;
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    check64("reset_state", {ready_o, result_o}, 65'd0);
    rst = 1'b1;

    run(1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, "u100_7");
    run(1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, "s_m7_2");
    run(1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "s7_m2");
    run(1'b0, 32'd5,          32'd0,        64'h00000000_00000000, "div0");
    run(1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, "s_min_m1");
    run(1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, "u_max_1");
    run(1'b1, 32'hFFFFFF9C,   32'd7,        64'hFFFFFFFE_FFFFFFF2, "s_m100_7");
    run(1'b0, 32'h80000000,   32'd3,        64'h00000002_2AAAAAAA, "u_min_3");
    run(1'b1, 32'h80000000,   32'd3,        64'hFFFFFFFE_D5555556, "s_min_3");
    run(1'b0, 32'hFFFFFFFF,   32'h0000FFFF, 64'h00000000_00010001, "u_max_ffff");
    run(1'b1, 32'd0,          32'd9,        64'h00000000_00000000, "s_zero_9");

    // Annul mid-division: no ready_o may follow.
    mid = (lat_of(1'b0, 32'd100, 32'd7) > 20) ? 10 : 3;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (mid + 1) @(negedge clk);
    start_i = 1'b0; annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o !== 1'b0) ok = 1'b1;
      @(negedge clk);
    end
    check64("annul_no_ready", 64'(ok), 64'd0);
    run(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "after_annul_9_3");

    // Reset asserted between edges while iterating.
    mid = (lat_of(1'b0, 32'd100, 32'd7) > 20) ? 20 : 3;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (mid + 1) @(negedge clk);
    #2 rst = 1'b0;
    #1 check64("rst_mid_on", {ready_o, result_o}, 65'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "after_rst_100_7");

    // Reset asserted between edges while holding a result in END.
    issue(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "rst_end_9_3");
    wait_ready("rst_end_9_3", ok);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check64("rst_in_end", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check64("rst_end_stays_clear", {ready_o, result_o}, 65'd0);
    start_i = 1'b0;
    repeat (3) @(negedge clk);

    check64("scoreboard_empty", 64'(sb.size()), 64'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      $display("FAIL pending_%s: got no ready_o expected result %h", e.name, e.res);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
